// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields and ALU flags into the multicycle
// controller, datapath enables/selects and debug state out of it.
interface multicycle_ctrl_if #(parameter int STATE_W = 4);
    logic [3:0]         Cond;
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         Rd;
    logic [3:0]         ALUFlags;
    logic               PCWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic               MemWrite;
    logic               AdrSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUControl;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic [3:0]         Flags;
    logic [STATE_W-1:0] State;
    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ALUControl, ImmSrc, RegSrc, Flags, State
    );
    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ALUControl, ImmSrc, RegSrc, Flags, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer, ALU decode, NZCV register and conditional
// write gating for the multicycle ARM datapath.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input logic CLK,
    input logic RESET,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;
    state_t      state, state_n;
    logic [3:0]  flags;
    logic        cond_ex_l, cond_ex;
    logic [15:0] cond_tbl;
    logic        n, z, c, v;
    logic        next_pc, branch, regw, memw, alu_op;
    logic [3:0]  cmd;
    logic        known, cmp, arith, s_eff, no_write, pc_src;
    logic [1:0]  alu_ctl, flag_w;
    assign {n, z, c, v} = flags;
    always_comb begin
        cond_tbl = {1'b0, 1'b1, z | (n ^ v), !z & (n ~^ v), n ^ v, n ~^ v, z | !c, !z & c,
                    !v, v, !n, n, !c, c, !z, z};
        cond_ex  = cond_tbl[bus.Cond];
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= FETCH;
            flags     <= 4'b0000;
            cond_ex_l <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DECODE) cond_ex_l <= cond_ex;
            if (flag_w[1] && cond_ex_l) flags[3:2] <= bus.ALUFlags[3:2];
            if (flag_w[0] && cond_ex_l) flags[1:0] <= bus.ALUFlags[1:0];
        end
    end
    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH:        state_n = DECODE;
            DECODE:       state_n = bus.Op == 2'b00 ? (bus.Funct[5] ? EXECI : EXECR) :
                                    bus.Op == 2'b01 ? MEMADR :
                                    bus.Op == 2'b10 ? BRANCH : FETCH;
            MEMADR:       state_n = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:        state_n = MEMWB;
            EXECR, EXECI: state_n = ALUWB;
            default:      state_n = FETCH;
        endcase
    end
    always_comb begin
        next_pc       = state == FETCH;
        branch        = state == BRANCH;
        regw          = state == MEMWB || state == ALUWB;
        memw          = state == MEMWR;
        alu_op        = state == EXECR || state == EXECI;
        bus.IRWrite   = state == FETCH;
        bus.AdrSrc    = state == MEMRD || state == MEMWR;
        bus.ALUSrcA   = state == FETCH || state == DECODE;
        bus.ALUSrcB   = (state == FETCH || state == DECODE) ? 2'b10 :
                        (state == MEMADR || state == EXECI || state == BRANCH) ? 2'b01 : 2'b00;
        bus.ResultSrc = (state == FETCH || state == DECODE || state == BRANCH) ? 2'b10 :
                        state == MEMWB ? 2'b01 : 2'b00;
    end
    always_comb begin
        cmd     = bus.Funct[4:1];
        known   = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
        cmp     = cmd inside {4'b1010, 4'b1011};
        arith   = cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b1011};
        s_eff   = bus.Funct[0] | cmp;
        alu_ctl = (cmd == 4'b0010 || cmd == 4'b1010) ? 2'b01 :
                  cmd == 4'b0000 ? 2'b10 : cmd == 4'b1100 ? 2'b11 : 2'b00;
        flag_w  = (alu_op && (known || cmp)) ? {s_eff, s_eff & arith} : 2'b00;
        // Writeback suppression is also needed in ALUWB, where ALUOp is already low
        no_write = (alu_op || state == ALUWB) && !known;
    end
    always_comb begin
        pc_src         = (branch || (regw && bus.Rd == 4'hF)) && cond_ex_l;
        bus.PCWrite    = next_pc || pc_src;
        bus.RegWrite   = regw && cond_ex_l && !no_write && bus.Rd != 4'hF;
        bus.MemWrite   = memw && cond_ex_l;
        bus.ALUControl = alu_op ? alu_ctl : 2'b00;
        bus.ImmSrc     = bus.Op;
        bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
        bus.Flags      = flags;
        bus.State      = state;
    end
endmodule
